mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 10, memory word-address width.
REQ-002 Parameter DATA_W, 16, memory word width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 f_req  input  1  fetch-port read request, held until f_ack.
REQ-006 f_addr  input  ADDR_W  fetch address, direct mode only.
REQ-007 f_ack  output  1  one-cycle pulse, fetch complete, f_rdata valid.
REQ-008 f_rdata  output  DATA_W  registered fetch read data.
REQ-009 d_req  input  1  data-port request, held until d_ack.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_ind  input  1  1 = indirect read (memory resolves mem[mem[addr]]).
REQ-012 d_addr  input  ADDR_W  data-port address.
REQ-013 d_wdata  input  DATA_W  write data.
REQ-014 d_ack  output  1  one-cycle pulse, data access complete.
REQ-015 d_rdata  output  DATA_W  registered data-port read data.
REQ-016 mem_addr  output  ADDR_W  to memory addr.
REQ-017 mem_addr_mode  output  1  to memory addr_mode.
REQ-018 mem_wr  output  1  to memory wr; memory writes on its rising edge.
REQ-019 mem_wdata  output  DATA_W  to memory data_in.
REQ-020 mem_rdata  input  DATA_W  from memory data_out (combinational read).
REQ-021 busy  output  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, RD, WS (write setup), WP (write pulse), WH (write hold), ACK.
REQ-023 IDLE: if any req high at the edge, latch winner id, address, d_we, d_ind, d_wdata into registers; go RD for read, WS for write; else stay.
REQ-024 Arbitration: one requester -> it wins; both -> the port not granted last wins (round-robin); last-grant register resets to data, so fetch wins the first contention.
REQ-025 mem_addr, mem_addr_mode, mem_wdata SHALL be driven only from the latched registers and stay stable from RD/WS entry through ACK.
REQ-026 RD: at its closing edge capture mem_rdata into the granted port's rdata register; go ACK.
REQ-027 WS: mem_wr = 0; go WP. WP: mem_wr = 1; go WH. WH: mem_wr = 0; go ACK.
REQ-028 mem_wr SHALL be a flop output (glitch-free), exactly one high cycle per write, never high outside WP.
REQ-029 Writes ignore d_ind: mem_addr_mode = 0 for every write and every fetch; = latched d_ind for data reads.
REQ-030 ACK: pulse the granted port's ack for exactly one cycle; update last-grant; go IDLE.
REQ-031 Latency: req sampled at edge k -> ack high in cycle after edge k+2 (read) or k+4 (write); IDLE re-samples at edge k+3 / k+5.
REQ-032 Requester SHALL drop req in the cycle after its ack; a req still high when IDLE re-samples starts a new transaction.
REQ-033 f_rdata/d_rdata hold their value until the next read completion on the same port; a write never changes d_rdata.
REQ-034 Input changes during a transaction SHALL not affect it (latched operands only).
REQ-035 Back-to-back: with both reqs held continuously, grants alternate F, D, F, D.

Reset
REQ-036 rst asserted (any state, including WP) SHALL immediately force IDLE, mem_wr = 0, f_ack = d_ack = 0, busy = 0, mem_addr = 0, mem_addr_mode = 0, mem_wdata = 0, f_rdata = d_rdata = 0, last-grant = data.
REQ-037 An interrupted transaction SHALL not be acked or retried; no mem_wr edge occurs after reset assertion until a new write reaches WP.

Verification
REQ-038 Fetch read: memory[5]=0x1234, f_req=1, f_addr=5 -> f_ack one cycle at k+2, f_rdata=0x1234, mem_addr_mode=0.
REQ-039 Data write then read: d_we=1, d_addr=0x191, d_wdata=0xBEEF -> one mem_wr pulse, d_ack at k+4; then read 0x191 -> d_rdata=0xBEEF.
REQ-040 Indirect read: memory[10]=0x0200, memory[0x200]=0x00AA, d_ind=1, d_addr=10 -> d_rdata=0x00AA; indirect write with d_ind=1 -> mem_addr_mode=0, write lands at d_addr.
REQ-041 Contention: f_req and d_req both held from reset for 4 transactions -> grant order F, D, F, D; no ack overlap; busy low exactly one cycle between transactions.
REQ-042 Reset during WP: assert rst while mem_wr=1 -> mem_wr falls asynchronously, no d_ack, state IDLE, all outputs at reset values.
REQ-043 Operand stability: change d_addr/d_wdata during WS/WP -> written location and data equal the values latched in IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter that shares one single-port memory
//                between a fetch (read-only) port and a data port with
//                write and indirect-read support.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_ind,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_addr_mode,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WS   = 3'd2,
        S_WP   = 3'd3,
        S_WH   = 3'd4,
        S_ACK  = 3'd5
    } state_t;

    state_t r_state;
    logic   r_gnt_d;    // granted port of the current transaction (1 = data)
    logic   r_last_d;   // port granted by the most recently acked transaction

    logic   w_any_req;
    logic   w_pick_d;

    assign w_any_req = f_req | d_req;
    // Data wins when alone, or under contention when fetch was served last.
    assign w_pick_d  = d_req & (~f_req | ~r_last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_gnt_d       <= 1'b0;
            r_last_d      <= 1'b1;
            f_ack         <= 1'b0;
            d_ack         <= 1'b0;
            f_rdata       <= '0;
            d_rdata       <= '0;
            mem_addr      <= '0;
            mem_addr_mode <= 1'b0;
            mem_wr        <= 1'b0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
        end else begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_d <= w_pick_d;
                        busy    <= 1'b1;
                        if (w_pick_d) begin
                            mem_addr      <= d_addr;
                            mem_wdata     <= d_wdata;
                            // Indirect addressing applies to data reads only.
                            mem_addr_mode <= d_ind & ~d_we;
                            r_state       <= d_we ? S_WS : S_RD;
                        end else begin
                            mem_addr      <= f_addr;
                            mem_addr_mode <= 1'b0;
                            r_state       <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (r_gnt_d) begin
                        d_rdata <= mem_rdata;
                    end else begin
                        f_rdata <= mem_rdata;
                    end
                    r_state <= S_ACK;
                end
                S_WS: begin
                    mem_wr  <= 1'b1;
                    r_state <= S_WP;
                end
                S_WP: begin
                    mem_wr  <= 1'b0;
                    r_state <= S_WH;
                end
                S_WH: begin
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    f_ack    <= ~r_gnt_d;
                    d_ack    <= r_gnt_d;
                    r_last_d <= r_gnt_d;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    mem_wr  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a memory model and
//                a transaction-level reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_req, f_ack;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req, d_we, d_ind, d_ack;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_addr_mode, mem_wr, busy;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_ind(d_ind), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_addr_mode(mem_addr_mode), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory seen by the DUT, and the bench's own view of what it should hold.
    logic [DATA_W-1:0] mem   [0:DEPTH-1];
    logic [DATA_W-1:0] model [0:DEPTH-1];
    logic [DATA_W-1:0] ptr_word;
    int                wr_cnt = 0;

    assign ptr_word  = mem[mem_addr];
    assign mem_rdata = mem_addr_mode ? mem[ptr_word[ADDR_W-1:0]] : ptr_word;

    always @(posedge clk) begin
        if (mem_wr === 1'b1) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
        end
    end

    int                n_cmp  = 0;
    int                n_fail = 0;
    logic [DATA_W-1:0] exp_f, exp_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        mem[a]   = v;
        model[a] = v;
    endtask

    // One single-port transaction; the requester drops req in its ack cycle.
    task automatic txn(input bit pd, input bit we_i, input bit ind_i,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                       input bit perturb);
        logic [DATA_W-1:0] ptr, exp_v;
        int n, wr0;
        bit got, we;
        we    = pd & we_i;
        ptr   = model[a];
        exp_v = (pd && ind_i) ? model[ptr[ADDR_W-1:0]] : ptr;
        @(negedge clk);
        if (pd) begin
            d_req = 1'b1; d_we = we; d_ind = ind_i; d_addr = a; d_wdata = wd;
            f_addr = ADDR_W'($urandom);
        end else begin
            f_req = 1'b1; f_addr = a;
            d_addr = ADDR_W'($urandom); d_wdata = DATA_W'($urandom);
            d_we = 1'($urandom); d_ind = 1'($urandom);
        end
        wr0 = wr_cnt; n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("mem_addr", mem_addr, a);
                check("addr_mode", mem_addr_mode, pd & ~we & ind_i);
                check("busy_txn", busy, 1);
            end
            if (we && n == 2) begin
                check("wr_pulse", mem_wr, 1);
                check("wr_addr_stable", mem_addr, a);
                check("wr_data_stable", mem_wdata, wd);
            end
            if (we && perturb && n <= 2) begin
                d_addr = ADDR_W'($urandom); d_wdata = DATA_W'($urandom); d_ind = 1'($urandom);
            end
            if (f_ack || d_ack) got = 1'b1;
        end
        f_req = 1'b0; d_req = 1'b0;
        check("ack_latency", n, we ? 5 : 3);
        check("ack_port", {f_ack, d_ack}, pd ? 2'b01 : 2'b10);
        check("busy_idle", busy, 0);
        if (we) model[a] = wd;
        else if (pd) exp_d = exp_v;
        else exp_f = exp_v;
        check("f_rdata", f_rdata, exp_f);
        check("d_rdata", d_rdata, exp_d);
        check("wr_count", wr_cnt - wr0, we ? 1 : 0);
    endtask

    initial begin
        logic [ADDR_W-1:0] fa, da, ra;
        logic [DATA_W-1:0] v;
        int ord [0:7];
        int nack, lows, ovl, n, wr0;
        bit any;

        for (int i = 0; i < DEPTH; i++) begin
            v = DATA_W'($urandom);
            mem[i] = v; model[i] = v;
        end
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_ind = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        exp_f = '0; exp_d = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_acks", {f_ack, d_ack}, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mode", mem_addr_mode, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", {f_rdata, d_rdata}, 0);
        rst = 1'b0;

        // Contention from reset: fetch first, then strict alternation
        fa = ADDR_W'($urandom); da = ADDR_W'($urandom);
        f_addr = fa; d_addr = da; d_we = 1'b0; d_ind = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 8; i++) ord[i] = 9;
        nack = 0; lows = 0; ovl = 0; n = 0;
        while (nack < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (busy == 1'b0) lows++;
            if (f_ack && d_ack) ovl++;
            if (f_ack) begin
                ord[nack] = 0; nack++;
                check("cont_f_rdata", f_rdata, model[fa]);
            end
            if (d_ack && nack < 8) begin
                ord[nack] = 1; nack++;
                check("cont_d_rdata", d_rdata, model[da]);
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        check("cont_acks", nack, 4);
        for (int i = 0; i < 4; i++) check("cont_order", ord[i], i % 2);
        check("cont_overlap", ovl, 0);
        check("cont_busy_gaps", lows, 4);
        exp_f = model[fa]; exp_d = model[da];

        // Directed fetch read
        poke(10'd5, 16'h1234);
        txn(1'b0, 1'b0, 1'b0, 10'd5, 16'h0, 1'b0);
        check("fetch_1234", f_rdata, 16'h1234);

        // Write then read back, with operands disturbed mid-write
        txn(1'b1, 1'b1, 1'b0, 10'h191, 16'hBEEF, 1'b1);
        txn(1'b1, 1'b0, 1'b0, 10'h191, 16'h0, 1'b0);
        check("readback_beef", d_rdata, 16'hBEEF);

        // Indirect read, then an indirect-flagged write lands directly
        poke(10'd10, 16'h0200);
        poke(10'h200, 16'h00AA);
        txn(1'b1, 1'b0, 1'b1, 10'd10, 16'h0, 1'b0);
        check("indirect_aa", d_rdata, 16'h00AA);
        txn(1'b1, 1'b1, 1'b1, 10'd10, 16'h5A5A, 1'b1);
        txn(1'b1, 1'b0, 1'b0, 10'd10, 16'h0, 1'b0);
        check("ind_write_direct", d_rdata, 16'h5A5A);

        // Randomized single-port traffic over a small address window
        for (int i = 0; i < 40; i++) begin
            ra = ADDR_W'($urandom_range(0, 15));
            v  = DATA_W'($urandom);
            txn(1'($urandom), 1'($urandom), 1'($urandom), ra, v, 1'($urandom));
        end

        // Reset asserted during the write pulse
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_ind = 1'b0; d_addr = 10'h3C; d_wdata = 16'hDEAD;
        wr0 = wr_cnt;
        @(negedge clk);
        @(negedge clk);
        check("wp_before_rst", mem_wr, 1);
        #2 rst = 1'b1;
        #1;
        check("wp_rst_mem_wr", mem_wr, 0);
        check("wp_rst_busy", busy, 0);
        check("wp_rst_acks", {f_ack, d_ack}, 0);
        check("wp_rst_mem_addr", mem_addr, 0);
        check("wp_rst_mode", mem_addr_mode, 0);
        check("wp_rst_wdata", mem_wdata, 0);
        check("wp_rst_rdata", {f_rdata, d_rdata}, 0);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_f = '0; exp_d = '0;
        any = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (f_ack || d_ack || busy) any = 1'b1;
        end
        check("no_ack_after_rst", any, 0);
        check("no_wr_after_rst", wr_cnt - wr0, 0);
        txn(1'b1, 1'b0, 1'b0, 10'h3C, 16'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
